// File: rtl/stopwatch_pkg.sv
// Shared constants and state type for the stopwatch time-keeping core.
// Imported by the counter top and the digit incrementor.
package stopwatch_pkg;

  localparam int DIG_W        = 4;
  localparam int NUM_DIG      = 4;
  localparam int LIM_DEC      = 10;
  localparam int LIM_SEC_TENS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  // Digit 3 is the seconds-tens place; every other place is decimal.
  function automatic int digit_limit(input int idx);
    return (idx == NUM_DIG - 1) ? LIM_SEC_TENS : LIM_DEC;
  endfunction

endpackage

// File: rtl/stopwatch_counter_lim_inc.sv
// Single limited incrementor: adds the carry-in and wraps to zero at LIMIT.
// Purely combinational; the caller owns the digit register.
module Lim_Inc
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = LIM_DEC,
  parameter int W     = DIG_W
) (
  input  logic [W-1:0] i_d,
  input  logic         i_ci,
  output logic [W-1:0] o_nxt,
  output logic         o_co
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, i_d} + {{W{1'b0}}, i_ci};
  assign o_co  = (w_sum >= (W+1)'(LIMIT));
  assign o_nxt = o_co ? '0 : w_sum[W-1:0];

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: run/pause/clear FSM, centisecond prescaler and SS.cc digits.
// Digits advance through a ripple chain of Lim_Inc instances on each tick.
//
// state    | meaning
// ST_IDLE  | stopped and zeroed, waiting for start_stop
// ST_RUN   | prescaler counting, digits advance on tick
// ST_PAUSE | prescaler and digits frozen, resumable
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_stop,
  input  logic             clear,
  output logic [DIG_W-1:0] d0,
  output logic [DIG_W-1:0] d1,
  output logic [DIG_W-1:0] d2,
  output logic [DIG_W-1:0] d3,
  output logic             running,
  output logic             wrap
);

  localparam int               CNT_W      = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  sw_state_e        r_state;
  logic [CNT_W-1:0] r_presc;
  logic [DIG_W-1:0] r_dig [NUM_DIG];
  logic             r_running;
  logic             r_wrap;

  logic             w_tick;
  logic [NUM_DIG:0] w_carry;
  logic [DIG_W-1:0] w_nxt [NUM_DIG];

  assign w_tick     = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_carry[0] = w_tick;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    Lim_Inc #(
      .LIMIT (digit_limit(g)),
      .W     (DIG_W)
    ) u_lim_inc (
      .i_d   (r_dig[g]),
      .i_ci  (w_carry[g]),
      .o_nxt (w_nxt[g]),
      .o_co  (w_carry[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= '0;
    end else begin
      // A clear on the rollover edge zeroes the count, so no wrap is reported.
      r_wrap <= w_carry[NUM_DIG] && !clear;
      case (r_state)
        ST_IDLE: begin
          r_presc <= '0;
          if (start_stop && !clear) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= '0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
              for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= w_nxt[i];
            end
            if (start_stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (clear) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= '0;
          end else if (start_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_presc   <= '0;
          r_running <= 1'b0;
          for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= '0;
        end
      endcase
    end
  end

  assign d0      = r_dig[0];
  assign d1      = r_dig[1];
  assign d2      = r_dig[2];
  assign d3      = r_dig[3];
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Time-keeping core of the stopwatch, directly downstream of the limited-incrementor chain.
- Holds four BCD digit registers (SS.cc format) and a run/pause/clear control FSM.
- Contains an internal prescaler that produces the 1/100 s tick.
- Its digit outputs feed the 7-segment display multiplexer.

Parameters:
- TICK_DIV, 1000000, clock cycles per centisecond tick (100 MHz → 100 Hz); legal range ≥2.
- CNT_W, $clog2(TICK_DIV), prescaler counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  one-cycle pulse, already debounced; toggles run/pause.
- clear  in  1  one-cycle pulse, already debounced; stops and zeroes the stopwatch.
- d0  out  4  centiseconds units, 0–9.
- d1  out  4  centiseconds tens, 0–9.
- d2  out  4  seconds units, 0–9.
- d3  out  4  seconds tens, 0–5.
- running  out  1  high while the FSM is in RUN.
- wrap  out  1  registered one-cycle pulse when the count rolls over from 59.99 to 00.00.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; d0..d3=0; prescaler=0; running=0; wrap=0.
  - A reset asserted mid-count takes effect immediately, with no clock edge required.
- FSM states: IDLE, RUN, PAUSE (2-bit encoding).
  - IDLE: start_stop → RUN. clear is a no-op (the block is already zeroed).
  - RUN: start_stop → PAUSE. clear → IDLE.
  - PAUSE: start_stop → RUN. clear → IDLE.
  - start_stop and clear in the same cycle: clear wins (→ IDLE, zeroed).
- Entering IDLE via clear: on that same edge, d0..d3=0 and prescaler=0.
- Prescaler:
  - Counts only in RUN.
  - tick = (state==RUN) && (prescaler==TICK_DIV-1).
  - On tick, the prescaler returns to 0.
  - The prescaler holds its value in PAUSE, so a resumed run does not lose a partial tick.
- Latency: start_stop sampled at edge k (IDLE → RUN) gives the first digit increment at edge k+TICK_DIV.
- Digit chain (ripple carry, combinational between registers):
  - ci0=tick.
  - Each digit computes next = (d+ci ≥ LIMIT) ? 0 : d+ci, with co = (d+ci ≥ LIMIT).
  - co of digit n drives ci of digit n+1.
  - Limits: d0=10, d1=10, d2=10, d3=6.
  - Digit registers load their next value only on tick; otherwise they hold.
- Wrap:
  - When co of d3 is 1, the count goes 59.99 → 00.00 and counting continues in RUN.
  - wrap=1 for exactly the cycle after that edge.
  - The state does not change on wrap.
- running is a registered decode of state==RUN: high from the edge that enters RUN until the edge that leaves it.
- start_stop arriving on the same edge as a tick: the tick still advances the digits, and the state change takes effect on that edge.
- Digit registers never hold values ≥ their limit; no other output values are reachable.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - Digit limit constants: LIM_DEC=10, LIM_SEC_TENS=6.
  - Digit width: DIG_W=4.
- Sub-module: four instances of the existing Lim_Inc, each with its limit parameter, chained ci→co.
- stopwatch_counter itself holds the FSM, the prescaler and the digit registers.
- Unreachable state 2'd3 recovers to IDLE on the next clock edge.

Test Plan (TICK_DIV=4 for simulation):
1. Reset, then hold start_stop and clear low for 20 cycles → d3..d0=00.00, running=0, wrap=0.
2. start_stop pulse at edge k → running=1 after k; d0=1 at edge k+4; d0=9, d1=0 at k+36; d1=1, d0=0 at k+40.
3. Run to 59.99, then one more tick → d3..d0=00.00 on the tick edge; wrap=1 for exactly one cycle; running stays 1.
4. Pause when prescaler=2 (at 00.05) and hold 10 cycles → digits frozen at 00.05. Resume → next increment to 00.06 occurs 2 cycles after the resume edge.
5. Cover the clear paths:
   - clear during RUN → 00.00, running=0, prescaler=0.
   - clear during PAUSE → same result.
   - start_stop and clear in the same cycle from RUN → IDLE, not PAUSE.
6. Assert reset_n low between clock edges at 12.34 → outputs read 0 before the next rising edge. Release reset, then start_stop → counting restarts from 00.00 with full TICK_DIV latency.
